// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the select lines of a 4:1 one-bit mux through channels 0..3 and samples each into a 4-bit word.
// Latency: one scan takes 4*(SETTLE_CYCLES+1) cycles from the start edge to word_valid.
// Backpressure: the completed word is held with word_valid=1 until word_ready; abort cancels from any state.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin one scan (level, sampled in IDLE only)
//   abort                 synchronous cancel back to IDLE, has priority over everything
//   mux_out               sampled mux output
//   addr1, addr0          mux select lines (registered)
//   busy                  high in every state except IDLE
//   word, word_valid      sampled word and its valid flag
//   word_ready            consumer accepts word (only looked at in HOLD)
//
// Build option: define MUX_SCAN_CONTINUOUS_EN to make a handshake in HOLD
// restart the scan immediately instead of returning to IDLE.

module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic       addr1,
  output logic       addr0,
  output logic       busy,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Counter reload: SETTLE lasts cnt = LOAD..0, i.e. SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] word_q, word_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 2'b00;
      cnt_q   <= 4'd0;
      word_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = SETTLE;
        SETTLE:  if (cnt_q == 4'd0) state_d = SAMPLE;
        SAMPLE:  state_d = (addr_q == 2'b11) ? HOLD : SETTLE;
        HOLD: begin
          if (word_ready) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
            state_d = SETTLE;
`else
            state_d = IDLE;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: select lines, settle counter, sampled word
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    if (abort) begin
      // Partial word is deliberately kept; only the sequencing state is cleared.
      addr_d = 2'b00;
      cnt_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d = 2'b00;
            cnt_d  = CNT_LOAD;
            word_d = 4'b0000;
          end
        end
        SETTLE: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        end
        SAMPLE: begin
          // Capture happens on the same edge the select lines move on.
          word_d[addr_q] = mux_out;
          if (addr_q != 2'b11) begin
            addr_d = addr_q + 2'b01;
            cnt_d  = CNT_LOAD;
          end
        end
        HOLD: begin
          if (word_ready) begin
            addr_d = 2'b00;
`ifdef MUX_SCAN_CONTINUOUS_EN
            cnt_d  = CNT_LOAD;
            word_d = 4'b0000;
`endif
          end
        end
        default: begin
          addr_d = 2'b00;
          cnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Outputs decode registers only; no input-to-output combinational path
  always_comb begin
    addr1      = addr_q[1];
    addr0      = addr_q[0];
    word       = word_q;
    busy       = (state_q != IDLE);
    word_valid = (state_q == HOLD);
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_CONTINUOUS_EN
  localparam int S = 1;
`else
  localparam int S = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       word_ready = 1'b0;
  logic [3:0] mux_in = 4'b0000;
  logic       mux_out;
  logic       addr1, addr0, busy, word_valid;
  logic [3:0] word;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux; unselected inputs may carry X
  assign mux_out = mux_in[{addr1, addr0}];

  mux_scan_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mux_out    (mux_out),
    .addr1      (addr1),
    .addr0      (addr0),
    .busy       (busy),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: time-based view of a scan. m_t counts edges since the start edge;
  // channel n is captured when m_t reaches (n+1)*(S+1).
  bit         m_busy = 1'b0;
  bit         m_hold = 1'b0;
  int         m_t = 0;
  logic [3:0] m_word = 4'b0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_hold = 1'b0; m_t = 0; m_word = 4'b0000;
    end else if (abort) begin
      m_busy = 1'b0; m_hold = 1'b0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1'b1; m_t = 0; m_word = 4'b0000; end
    end else if (m_hold) begin
      if (word_ready) begin
        m_hold = 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
        m_t = 0; m_word = 4'b0000;
`else
        m_busy = 1'b0;
`endif
      end
    end else begin
      int ch;
      m_t++;
      if (m_t % (S + 1) == 0) begin
        ch = m_t / (S + 1) - 1;
        m_word[ch[1:0]] = mux_in[ch[1:0]];
        if (ch == 3) m_hold = 1'b1;
      end
    end
  end

  function automatic logic [1:0] m_addr();
    int a;
    if (!m_busy) return 2'b00;
    if (m_hold)  return 2'b11;
    a = m_t / (S + 1);
    return a[1:0];
  endfunction

  // Per-cycle comparison against the model, after the edge has settled
  always @(posedge clk) begin
    #2;
    chk("cyc_addr",  {2'b00, addr1, addr0}, {2'b00, m_addr()});
    chk("cyc_busy",  {3'b000, busy},        {3'b000, m_busy});
    chk("cyc_valid", {3'b000, word_valid},  {3'b000, m_hold});
    chk("cyc_word",  word,                  m_word);
  end

  // Pulse start; returns at the first falling edge after the start edge E0
  task automatic scan_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n, input int lim);
    n = 0;
    while (word_valid !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

`ifndef MUX_SCAN_CONTINUOUS_EN
  task automatic run_x(input logic [3:0] v);
    logic [3:0] m;
    scan_start();
    for (int k = 0; k < 4 * (S + 1); k++) begin
      m = 4'bxxxx;
      m[k / (S + 1)] = v[k / (S + 1)];
      mux_in = m;
      @(negedge clk);
    end
    chk("x_word",  word, v);
    chk("x_clean", {3'b000, $isunknown(word)}, 4'b0000);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    mux_in = 4'b0000;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] exp_seq [12];
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_addr",  {2'b00, addr1, addr0}, 4'b0000);
    chk("rst_word",  word, 4'b0000);
    chk("rst_valid", {3'b000, word_valid}, 4'b0000);
    chk("rst_busy",  {3'b000, busy}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef MUX_SCAN_CONTINUOUS_EN
    // Basic scan with backpressure: in0..in3 = 1,0,1,1
    mux_in = 4'b1101;
    scan_start();
    chk("busy_after_e0", {3'b000, busy}, 4'b0001);
    for (int k = 0; k < 12; k++) begin
      chk("addr_seq", {2'b00, addr1, addr0}, {2'b00, exp_seq[k]});
      chk("valid_early", {3'b000, word_valid}, 4'b0000);
      @(negedge clk);
    end
    chk("valid_at_e12", {3'b000, word_valid}, 4'b0001);
    chk("word_basic", word, 4'b1101);
    mux_in = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      chk("bp_word",  word, 4'b1101);
      chk("bp_valid", {3'b000, word_valid}, 4'b0001);
      chk("bp_addr",  {2'b00, addr1, addr0}, 4'b0011);
      @(negedge clk);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    chk("xfer_busy",  {3'b000, busy}, 4'b0000);
    chk("xfer_valid", {3'b000, word_valid}, 4'b0000);
    chk("xfer_addr",  {2'b00, addr1, addr0}, 4'b0000);

    // X isolation, then the complement pattern
    run_x(4'b0110);
    run_x(4'b1001);

    // Asynchronous reset mid-SETTLE of channel 1
    mux_in = 4'b1111;
    scan_start();
    repeat (4) @(negedge clk);
    chk("pre_rst_word", word, 4'b0001);
    chk("pre_rst_addr", {2'b00, addr1, addr0}, 4'b0001);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_addr",  {2'b00, addr1, addr0}, 4'b0000);
    chk("arst_word",  word, 4'b0000);
    chk("arst_valid", {3'b000, word_valid}, 4'b0000);
    chk("arst_busy",  {3'b000, busy}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort in channel-2 SETTLE with start held into the following IDLE cycle
    mux_in = 4'b0101;
    word_ready = 1'b1;
    scan_start();
    repeat (6) @(negedge clk);
    chk("abort_at_ch2", {2'b00, addr1, addr0}, 4'b0010);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",  {3'b000, busy}, 4'b0000);
    chk("abort_addr",  {2'b00, addr1, addr0}, 4'b0000);
    chk("abort_valid", {3'b000, word_valid}, 4'b0000);
    chk("abort_word",  word, 4'b0001);
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", {3'b000, busy}, 4'b0001);
    chk("restart_addr", {2'b00, addr1, addr0}, 4'b0000);
    wait_valid(n, 40);
    chk("restart_lat", n[3:0], 4'd12);
    chk("restart_word", word, 4'b0101);
    @(negedge clk);
    chk("restart_done", {3'b000, busy}, 4'b0001 ^ 4'b0001);

    // Back-to-back with start held: one IDLE cycle between transfer and next E0
    mux_in = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    wait_valid(n, 40);
    chk("b2b_lat",  n[3:0], 4'd12);
    chk("b2b_word", word, 4'b1010);
    @(negedge clk);
    chk("b2b_gap",  {3'b000, busy}, 4'b0000);
    @(negedge clk);
    chk("b2b_again", {3'b000, busy}, 4'b0001);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    word_ready = 1'b0;
    chk("b2b_abort", {3'b000, busy}, 4'b0000);
`else
    // Continuous scanning: word_valid every 9 cycles, busy held until abort
    word_ready = 1'b1;
    mux_in = 4'b0110;
    scan_start();
    wait_valid(n, 40);
    chk("cont_first", n[3:0], 4'd8);
    chk("cont_word",  word, 4'b0110);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      n = 1;
      while (word_valid !== 1'b1 && n < 40) begin
        chk("cont_busy", {3'b000, busy}, 4'b0001);
        @(negedge clk);
        n++;
      end
      chk("cont_period", n[3:0], 4'd9);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("cont_abort_busy", {3'b000, busy}, 4'b0000);
    @(negedge clk);
    chk("cont_stays_idle", {3'b000, busy}, 4'b0000);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
